// File: rtl/alu_pkg.sv
// Shared types and constants for the two-client ALU arbiter.
package alu_pkg;
  localparam int ALU_WIDTH = 4;
  localparam int ALU_OPW   = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_SHR;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals around the arbiter.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH:0]   alu_result;
  logic             resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [WIDTH:0]   resp_data;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result,
    output resp_valid, resp_id, resp_data, resp_err, busy,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result,
    input  resp_valid, resp_id, resp_data, resp_err, busy,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer moves past the winner on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr_q, ptr_d;  // 1 = requester 1 wins a tie

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    ptr_d = ptr_q;
    if (advance) ptr_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; one operation in flight.
//  state   | meaning
//  ST_IDLE | waiting for a request, grant is live on reqN_ready
//  ST_EXEC | latched operands on alu_*, result captured at end of cycle
//  ST_RESP | response held on resp_* until resp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH:0]   data_q, data_d;
  logic             rid_q, rid_d, err_q, err_d;
  logic             rvalid_q, rvalid_d, busy_q, busy_d;
  logic [1:0]       arb_valid, grant;
  logic             idle, accept, op_err;

  // Mask with rst so both readies read 0 while reset is held.
  assign idle      = (state_q == ST_IDLE) && !rst;
  assign arb_valid = {bus.req1_valid, bus.req0_valid} & {2{idle}};
  assign accept    = |grant;
  assign op_err    = !is_legal_op(op_q) ||
                     (((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0));

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid   (arb_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    data_d  = data_q;
    rid_d   = rid_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = grant[1] ? bus.req1_a  : bus.req0_a;
          b_d     = grant[1] ? bus.req1_b  : bus.req0_b;
          op_d    = grant[1] ? bus.req1_op : bus.req0_op;
          id_d    = grant[1];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rid_d   = id_q;
        data_d  = op_err ? '0 : bus.alu_result;
        err_d   = op_err;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rvalid_d = (state_d == ST_RESP);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      data_q   <= '0;
      rid_q    <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      data_q   <= data_d;
      rid_q    <= rid_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_id    = rid_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;
  typedef struct {
    logic [3:0] a, b, op;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;
  req_t q0[$], q1[$];
  logic [6:0] rlog[$];  // {id, err, data}

  // Calculator ALU; divide by zero and illegal codes give junk the arbiter must hide.
  function automatic logic [4:0] calc(input logic [3:0] a, b, op);
    logic [4:0] x, y;
    x = {1'b0, a};
    y = {1'b0, b};
    case (op)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x * y;
      4'd3: return (b == 4'd0) ? 5'h1f : x / y;
      4'd4: return (b == 4'd0) ? 5'h1f : x % y;
      4'd5: return x & y;
      4'd6: return x | y;
      4'd7: return x ^ y;
      4'd8: return x << y;
      4'd9: return x >> y;
      default: return 5'h1f;
    endcase
  endfunction

  function automatic logic [5:0] ref_resp(input logic [3:0] a, b, op);
    logic err;
    err = (op > 4'd9) || (((op == 4'd3) || (op == 4'd4)) && (b == 4'd0));
    return err ? 6'b100000 : {1'b0, calc(a, b, op)};
  endfunction

  always_comb bus.alu_result = calc(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, its age and the tie-break favourite.
  bit         m_out = 1'b0;
  int         m_age = 0;
  bit         m_fav1 = 1'b0;
  logic [3:0] m_a = '0, m_b = '0, m_op = '0;
  logic       m_id = 1'b0;

  function automatic int exp_grant();
    if (rst || m_out) return -1;
    if (bus.req0_valid && bus.req1_valid) return m_fav1 ? 1 : 0;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_grant();
    if (rst) begin
      m_out = 1'b0; m_fav1 = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_id = 1'b0;
    end else if (m_out) begin
      if (m_age >= 1 && bus.resp_ready) m_out = 1'b0;
      else m_age = 1;
    end else if (g >= 0) begin
      m_out = 1'b1; m_age = 0; m_id = (g == 1);
      m_a  = (g == 1) ? bus.req1_a  : bus.req0_a;
      m_b  = (g == 1) ? bus.req1_b  : bus.req0_b;
      m_op = (g == 1) ? bus.req1_op : bus.req0_op;
      m_fav1 = (g == 0);
    end
  end

  always @(negedge clk) begin
    int g;
    logic [5:0] r;
    if (started) begin
      g = exp_grant();
      check("req0_ready", bus.req0_ready, (g == 0));
      check("req1_ready", bus.req1_ready, (g == 1));
      check("busy", bus.busy, m_out);
      check("resp_valid", bus.resp_valid, (m_out && m_age >= 1));
      check("alu_a", bus.alu_a, m_a);
      check("alu_b", bus.alu_b, m_b);
      check("alu_op", bus.alu_op, m_op);
      if (m_out && m_age >= 1) begin
        r = ref_resp(m_a, m_b, m_op);
        check("resp_data", bus.resp_data, r[4:0]);
        check("resp_err", bus.resp_err, r[5]);
        check("resp_id", bus.resp_id, m_id);
      end
      if (bus.resp_valid && bus.resp_ready)
        rlog.push_back({bus.resp_id, bus.resp_err, bus.resp_data});
    end
  end

  // Requester drivers: present queue head, pop once accepted.
  initial begin
    bit acc;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    forever begin
      @(negedge clk);
      acc = bus.req0_valid && bus.req0_ready;
      @(posedge clk);
      #1;
      if (acc && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_a = q0[0].a; bus.req0_b = q0[0].b; bus.req0_op = q0[0].op;
      end else bus.req0_valid = 1'b0;
    end
  end

  initial begin
    bit acc;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    forever begin
      @(negedge clk);
      acc = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (acc && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_a = q1[0].a; bus.req1_b = q1[0].b; bus.req1_op = q1[0].op;
      end else bus.req1_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    do begin tick(); n++; end
    while ((q0.size() > 0 || q1.size() > 0 || bus.busy) && n < 200);
    check({name, "_drain_timeout"}, (n >= 200), 0);
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    while (!bus.resp_valid && n < 50) begin tick(); n++; end
    check({name, "_resp_timeout"}, (n >= 50), 0);
  endtask

  task automatic push(input bit id, input logic [3:0] a, b, op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    if (id) q1.push_back(r); else q0.push_back(r);
  endtask

  initial begin
    int base, n;
    bus.resp_ready = 1'b1;

    // Reference model pinned to hand-computed results.
    check("ref_add", ref_resp(4'd10, 4'd2, 4'd0), 6'd12);
    check("ref_mul", ref_resp(4'd4, 4'd5, 4'd2), 6'd20);
    check("ref_sub_wrap", ref_resp(4'd3, 4'd5, 4'd1), 6'd30);
    check("ref_mul_trunc", ref_resp(4'd15, 4'd15, 4'd2), 6'd1);
    check("ref_div0", ref_resp(4'd5, 4'd0, 4'd3), 6'b100000);
    check("ref_illegal", ref_resp(4'd1, 4'd1, 4'd12), 6'b100000);

    // Contention: both requesters valid while reset is still held.
    push(0, 4'd4, 4'd5, 4'd2);  push(1, 4'd10, 4'd5, 4'd7);
    push(0, 4'd1, 4'd2, 4'd0);  push(1, 4'd9, 4'd3, 4'd1);
    push(0, 4'd7, 4'd7, 4'd5);  push(1, 4'd6, 4'd2, 4'd6);
    tick(); started = 1'b1;
    tick();
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_resp_data", bus.resp_data, 0);
    rst = 1'b0;
    wait_drain("contention");
    check("cont_count", rlog.size(), 6);
    if (rlog.size() == 6) begin
      check("cont_r0", rlog[0], {1'b0, 1'b0, 5'd20});
      check("cont_r1", rlog[1], {1'b1, 1'b0, 5'd15});
      check("cont_r2", rlog[2], {1'b0, 1'b0, 5'd3});
      check("cont_r3", rlog[3], {1'b1, 1'b0, 5'd6});
      check("cont_r4", rlog[4], {1'b0, 1'b0, 5'd7});
      check("cont_r5", rlog[5], {1'b1, 1'b0, 5'd6});
    end

    // Single request with exact latency.
    push(0, 4'd10, 4'd2, 4'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req0_ready && n < 5);
    check("single_accept_timeout", (n >= 5), 0);
    @(negedge clk);
    check("single_t1_busy", bus.busy, 1);
    check("single_t1_valid", bus.resp_valid, 0);
    @(negedge clk);
    check("single_t2_valid", bus.resp_valid, 1);
    check("single_t2_data", bus.resp_data, 12);
    check("single_t2_id", bus.resp_id, 0);
    check("single_t2_err", bus.resp_err, 0);
    check("single_t2_busy", bus.busy, 1);
    @(negedge clk);
    check("single_t3_valid", bus.resp_valid, 0);
    check("single_t3_busy", bus.busy, 0);
    tick();

    // Backpressure with req0 left pending.
    base = rlog.size();
    bus.resp_ready = 1'b0;
    push(1, 4'd8, 4'd3, 4'd4);
    wait_resp("bp");
    push(0, 4'd3, 4'd3, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", bus.resp_valid, 1);
      check("bp_data", bus.resp_data, 2);
      check("bp_id", bus.resp_id, 1);
      check("bp_ready0", bus.req0_ready, 0);
      check("bp_ready1", bus.req1_ready, 0);
    end
    bus.resp_ready = 1'b1;
    tick();
    check("bp_release_valid", bus.resp_valid, 0);
    check("bp_release_ready0", bus.req0_ready, 1);
    wait_drain("bp");
    check("bp_count", rlog.size() - base, 2);
    if (rlog.size() - base == 2) begin
      check("bp_r0", rlog[base], {1'b1, 1'b0, 5'd2});
      check("bp_r1", rlog[base+1], {1'b0, 1'b0, 5'd6});
    end

    // Error override and recovery.
    base = rlog.size();
    push(0, 4'd5, 4'd0, 4'd3);
    push(0, 4'd9, 4'd9, 4'd12);
    push(0, 4'd15, 4'd1, 4'd9);
    wait_drain("err");
    check("err_count", rlog.size() - base, 3);
    if (rlog.size() - base == 3) begin
      check("err_div0", rlog[base], {1'b0, 1'b1, 5'd0});
      check("err_illegal", rlog[base+1], {1'b0, 1'b1, 5'd0});
      check("err_shr", rlog[base+2], {1'b0, 1'b0, 5'd7});
    end

    // Reset during EXEC.
    base = rlog.size();
    push(0, 4'd1, 4'd1, 4'd0);
    n = 0;
    do begin tick(); n++; end while (!(bus.busy && !bus.resp_valid) && n < 20);
    check("rst_exec_timeout", (n >= 20), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_exec_busy", bus.busy, 0);
    check("rst_exec_valid", bus.resp_valid, 0);
    for (int i = 0; i < 4; i++) tick();

    // Reset during RESP.
    bus.resp_ready = 1'b0;
    push(0, 4'd2, 4'd2, 4'd0);
    wait_resp("rst_resp");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    check("rst_resp_busy", bus.busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    for (int i = 0; i < 4; i++) tick();
    check("rst_no_stale", rlog.size() - base, 0);

    // Pointer back on requester 0 after reset.
    push(0, 4'd2, 4'd3, 4'd0);
    push(1, 4'd3, 4'd3, 4'd5);
    wait_drain("post_rst");
    check("post_rst_count", rlog.size() - base, 2);
    if (rlog.size() - base == 2) begin
      check("post_rst_r0", rlog[base], {1'b0, 1'b0, 5'd5});
      check("post_rst_r1", rlog[base+1], {1'b1, 1'b0, 5'd3});
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
